// File: rtl/step_tick_gen.sv
// ---------------------------------------------------------------------------
// step_tick_gen
//
// Pacing stage for the board's 4-bit down counters. It produces a
// single-cycle clock-enable pulse (o_tick) at a selectable power-of-two rate.
// The counters then run on CLOCK_50 qualified by o_tick instead of on a
// divided clock. Two KEY buttons are synchronised and debounced here. One
// toggles between RUN and PAUSE. The other issues one tick per press while
// paused.
//
// Optional feature macro: STEP_AUTOREPEAT_EN
//   defined   : in PAUSE, holding the step key also ticks on every prescaler
//               wrap after the initial press tick, until the key is released.
//   undefined : exactly one tick per step press, whatever the hold time.
//
// Parameters
//   DIV_WIDTH        width of the free-running prescaler (max period 2^DIV_WIDTH)
//   DEBOUNCE_CYCLES  consecutive stable samples needed to change a debounced
//                    level (>= 2)
//   DB_WIDTH         debounce counter width, 2^DB_WIDTH > DEBOUNCE_CYCLES
//
// Ports
//   i_clk           system clock (CLOCK_50)
//   i_rst           synchronous, active-low reset
//   i_div_sel[4:0]  rate select: tick period 2^(n+1), n = min(div_sel, DIV_WIDTH-1)
//   i_key_pause_n   raw pause button, active-low, asynchronous
//   i_key_step_n    raw step button, active-low, asynchronous
//   o_tick          one-cycle enable pulse, registered
//   o_paused        1 while in PAUSE mode, registered
//   o_tick_count    number of ticks emitted, wraps 255 -> 0
// ---------------------------------------------------------------------------
module step_tick_gen #(
  parameter int DIV_WIDTH       = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_WIDTH        = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_div_sel,
  input  logic       i_key_pause_n,
  input  logic       i_key_step_n,
  output logic       o_tick,
  output logic       o_paused,
  output logic [7:0] o_tick_count
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } mode_t;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Key channel index 0 is the pause key, index 1 is the step key.
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_db;
  logic [1:0]          r_dbDly;
  logic [1:0]          r_fall;
  logic [1:0]          r_press;
  logic [DB_WIDTH-1:0] r_dbCnt [2];

  logic [DIV_WIDTH-1:0] r_prescaler;
  logic                 r_tick;
  logic [7:0]           r_tickCount;
  mode_t                r_mode;

  logic [4:0]           w_n;
  logic [DIV_WIDTH-1:0] w_mask;
  logic                 w_wrap;
  logic                 w_pausePress;
  logic                 w_stepPress;
  logic                 w_repeat;
  logic                 w_tickNext;

  // Both keys pass through a two-flop synchroniser and then a restartable
  // debounce counter. The debounced level only moves after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it, so a single bounce restarts
  // the count. The press pulse goes through two register stages (falling
  // edge, then pulse). This fixes the press latency at DEBOUNCE_CYCLES+3
  // cycles after the raw key is first sampled low. A release produces no
  // pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_db       <= 2'b11;
      r_dbDly    <= 2'b11;
      r_fall     <= 2'b00;
      r_press    <= 2'b00;
      r_dbCnt[0] <= '0;
      r_dbCnt[1] <= '0;
    end else begin
      r_sync1 <= {i_key_step_n, i_key_pause_n};
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_dbCnt[k] == DB_LAST) begin
            r_db[k]    <= r_sync2[k];
            r_dbCnt[k] <= '0;
          end else begin
            r_dbCnt[k] <= r_dbCnt[k] + DB_WIDTH'(1);
          end
        end else begin
          r_dbCnt[k] <= '0;
        end
      end
      r_dbDly <= r_db;
      r_fall  <= r_dbDly & ~r_db;
      r_press <= r_fall;
    end
  end

  assign w_pausePress = r_press[0];
  assign w_stepPress  = r_press[1];

  // Clamp the rate select and build a mask covering prescaler bits [n:0].
  // A wrap is the cycle where all of those bits are ones.
  always_comb begin
    w_n = i_div_sel;
    if (int'(i_div_sel) >= DIV_WIDTH) begin
      w_n = 5'(DIV_WIDTH - 1);
    end
    w_mask = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      w_mask[i] = (i <= int'(w_n));
    end
  end

  assign w_wrap = &(r_prescaler | ~w_mask);

`ifdef STEP_AUTOREPEAT_EN
  logic r_stepHeld;

  // Auto-repeat is armed by a step press accepted in PAUSE. It stays armed
  // while the debounced step level is low, and clears on release or on
  // leaving PAUSE. It only adds wrap ticks after the initial press tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stepHeld <= 1'b0;
    end else if (r_mode == ST_PAUSE && w_stepPress && !w_pausePress) begin
      r_stepHeld <= 1'b1;
    end else if (r_db[1] || r_mode == ST_RUN || w_pausePress) begin
      r_stepHeld <= 1'b0;
    end
  end

  assign w_repeat = r_stepHeld && w_wrap;
`else
  assign w_repeat = 1'b0;
`endif

  // The tick decision uses the mode held before any pause toggle in the same
  // cycle. As a result, a simultaneous pause+step from PAUSE still gives its
  // step tick, and the same combination from RUN ignores the step.
  assign w_tickNext = (r_mode == ST_RUN   && w_wrap) ||
                      (r_mode == ST_PAUSE && (w_stepPress || w_repeat));

  // Mode FSM, prescaler, tick and tick counter. The prescaler keeps running
  // in PAUSE so the RUN phase is preserved across a pause/resume. The counter
  // follows the registered tick one cycle later.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
      r_tickCount <= '0;
      r_mode      <= ST_RUN;
    end else begin
      r_prescaler <= r_prescaler + DIV_WIDTH'(1);
      r_tick      <= w_tickNext;
      if (r_tick) begin
        r_tickCount <= r_tickCount + 8'd1;
      end
      if (w_pausePress) begin
        r_mode <= (r_mode == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
    end
  end

  assign o_tick       = r_tick;
  assign o_paused     = (r_mode == ST_PAUSE);
  assign o_tick_count = r_tickCount;

endmodule

// File: tb/tb_step_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_step_tick_gen
//
// Bench for step_tick_gen with DIV_WIDTH=8, DEBOUNCE_CYCLES=4. The expected
// tick cycles are worked out from the rate and press-latency rules. They are
// pushed into a queue as each stimulus is driven. A negedge monitor pops one
// entry for every tick the DUT emits. 'cyc' counts non-reset clock edges, so
// at a negedge it names the cycle that edge started.
// ---------------------------------------------------------------------------
module tb_step_tick_gen;

  localparam int DIV_WIDTH = 8;
  localparam int DEB       = 4;
  localparam int DB_WIDTH  = 3;

`ifdef STEP_AUTOREPEAT_EN
  localparam int REP = 2;
`else
  localparam int REP = 0;
`endif

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic [4:0] divSel    = 5'd2;
  logic       keyPauseN = 1'b1;
  logic       keyStepN  = 1'b1;
  logic       tick;
  logic       paused;
  logic [7:0] tickCount;

  int cyc         = 0;
  int testsRun    = 0;
  int testsFailed = 0;
  int expTicks[$];

  step_tick_gen #(
    .DIV_WIDTH      (DIV_WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .DB_WIDTH       (DB_WIDTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_div_sel    (divSel),
    .i_key_pause_n(keyPauseN),
    .i_key_step_n (keyStepN),
    .o_tick       (tick),
    .o_paused     (paused),
    .o_tick_count (tickCount)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Cycle index since the last reset edge.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Every tick the DUT emits must match the next expected tick cycle.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (expTicks.size() == 0) checkOutput("spuriousTick", cyc, -1);
      else                      checkOutput("tickCycle", cyc, expTicks.pop_front());
    end
  end

  task automatic waitCycle(input int n);
    for (int i = 0; i < 100000 && cyc < n; i++) @(negedge clk);
    if (cyc != n) checkOutput("waitCycle", cyc, n);
  endtask

  // Drive both raw keys so the new levels are first sampled at edge atEdge.
  task automatic applyStimulus(input int atEdge, input logic pauseN, input logic stepN);
    waitCycle(atEdge - 1);
    keyPauseN = pauseN;
    keyStepN  = stepN;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b0;
    keyPauseN = 1'b1;
    keyStepN  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstTick", tick, 0);
    checkOutput("rstPaused", paused, 0);
    checkOutput("rstCount", tickCount, 0);
    rst = 1'b1;
  endtask

  task automatic endPhase(input string tag);
    checkOutput(tag, expTicks.size(), 0);
    expTicks.delete();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, testsRun %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // RUN at div_sel=2: period 8, first tick in cycle 8.
    divSel = 5'd2;
    doReset();
    expTicks.push_back(8);
    expTicks.push_back(16);
    expTicks.push_back(24);
    waitCycle(24);
    checkOutput("countAt24", tickCount, 2);
    waitCycle(25);
    checkOutput("countAt25", tickCount, 3);
    checkOutput("pausedRun", paused, 0);
    waitCycle(30);
    endPhase("pendingRun");

    // div_sel above the range clamps to n=7: period 256.
    divSel = 5'd31;
    doReset();
    expTicks.push_back(256);
    expTicks.push_back(512);
    waitCycle(520);
    checkOutput("countClamp", tickCount, 2);
    endPhase("pendingClamp");

    // Pause press at edge 10 lands in cycle 17, paused from 18.
    divSel = 5'd2;
    doReset();
    expTicks.push_back(8);
    expTicks.push_back(16);
    expTicks.push_back(48);
    if (REP != 0) begin
      expTicks.push_back(56);
      expTicks.push_back(64);
    end
    applyStimulus(10, 1'b0, 1'b1);
    waitCycle(17);
    checkOutput("pausedAt17", paused, 0);
    waitCycle(18);
    checkOutput("pausedAt18", paused, 1);
    applyStimulus(30, 1'b1, 1'b1);
    // Step key held from edge 40 for 20 cycles: one tick in cycle 48.
    applyStimulus(40, 1'b1, 1'b0);
    waitCycle(48);
    checkOutput("countAt48", tickCount, 2);
    waitCycle(49);
    checkOutput("countAt49", tickCount, 3);
    applyStimulus(60, 1'b1, 1'b1);
    // Bouncing step key: low 3, high 1, five times. No press may result.
    for (int r = 0; r < 5; r++) begin
      applyStimulus(80 + 4 * r, 1'b1, 1'b0);
      applyStimulus(83 + 4 * r, 1'b1, 1'b1);
    end
    waitCycle(115);
    checkOutput("countBounce", tickCount, 3 + REP);
    checkOutput("pausedBounce", paused, 1);
    // Pause and step together from PAUSE: one step tick in 129, RUN again.
    expTicks.push_back(129);
    expTicks.push_back(136);
    expTicks.push_back(144);
    applyStimulus(121, 1'b0, 1'b0);
    waitCycle(128);
    checkOutput("pausedAt128", paused, 1);
    waitCycle(129);
    checkOutput("pausedAt129", paused, 0);
    applyStimulus(140, 1'b1, 1'b1);
    waitCycle(150);
    checkOutput("countResume", tickCount, 6 + REP);
    endPhase("pendingPause");

    // Reset mid-PAUSE while a step press is about to tick (cycle 38).
    divSel = 5'd2;
    doReset();
    expTicks.push_back(8);
    applyStimulus(2, 1'b0, 1'b1);
    waitCycle(10);
    checkOutput("pausedD", paused, 1);
    applyStimulus(20, 1'b1, 1'b1);
    applyStimulus(30, 1'b1, 1'b0);
    waitCycle(37);
    checkOutput("countBeforeRst", tickCount, 1);
    endPhase("pendingBeforeRst");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstTick", tick, 0);
    checkOutput("midRstPaused", paused, 0);
    checkOutput("midRstCount", tickCount, 0);
    rst = 1'b1;
    // Step still held: its fresh press arrives in RUN and is ignored.
    expTicks.push_back(8);
    expTicks.push_back(16);
    waitCycle(20);
    checkOutput("countAfterRst", tickCount, 2);
    checkOutput("pausedAfterRst", paused, 0);
    keyStepN = 1'b1;
    endPhase("pendingAfterRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
